// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if
// Bundles the two requester ports, the shared peripheral port and the owner
// indication of periph_bus_arbiter.
//   slave  modport : arbiter view (takes requests, drives grants/strobes)
//   master modport : requester/peripheral view (drives requests and read data)
// Signals per master X in {0,1}:
//   mX_req/mX_lock/mX_we/mX_addr/mX_wdata   request side
//   mX_gnt/mX_rvalid/mX_rerr/mX_rdata       response side
// Peripheral: per_addr/per_wdata/per_rd/per_wr out of the arbiter, per_rdata in.
// owner: index of the master that last won arbitration.
`timescale 1ns/1ps
interface periph_bus_arbiter_if;
  logic        m0_req;
  logic        m0_lock;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic        m0_rerr;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_lock;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic        m1_rerr;
  logic [31:0] m1_rdata;

  logic [31:0] per_addr;
  logic [31:0] per_wdata;
  logic        per_rd;
  logic        per_wr;
  logic [31:0] per_rdata;
  logic        owner;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    input  per_rdata,
    output m0_gnt, m0_rvalid, m0_rerr, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rerr, m1_rdata,
    output per_addr, per_wdata, per_rd, per_wr, owner
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    output per_rdata,
    input  m0_gnt, m0_rvalid, m0_rerr, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rerr, m1_rdata,
    input  per_addr, per_wdata, per_rd, per_wr, owner
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
// Two-master round-robin arbiter in front of a single peripheral register
// window. Each access walks IDLE -> ACCESS -> DONE; every output is a register.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : periph_bus_arbiter_if.slave (master requests, peripheral port, owner)
// Parameters: BASE_ADDR/TOP_ADDR bound the valid word-address window,
//   LOCK_MAX caps consecutive locked accesses by one owner.
// Optional feature: define PARB_LOCK_EN to honour mX_lock (back-to-back
//   accesses from DONE); without it the lock inputs are ignored.
`timescale 1ns/1ps
module periph_bus_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] TOP_ADDR  = 32'h4000_0014,
  parameter int          LOCK_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  periph_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Word aligned and inside the inclusive peripheral window.
  function automatic logic addr_ok(input logic [31:0] a);
    addr_ok = (a[1:0] == 2'b00) && (a >= BASE_ADDR) && (a <= TOP_ADDR);
  endfunction

  state_t      state_r, state_s;
  logic        ptr_r, ptr_s;        // 1 = m1 has priority on a tie
  logic        owner_r, owner_s;
  logic        we_r, we_s;
  logic        valid_r, valid_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] rdata_r, rdata_s;
  logic [1:0]  gnt_r, gnt_s;
  logic [1:0]  rvalid_r, rvalid_s;
  logic [1:0]  rerr_r, rerr_s;
  logic        rd_r, rd_s;
  logic        wr_r, wr_s;
  logic [1:0]  req_s;
  logic [1:0]  lock_s;
  logic        winner_s;
  logic        load_s;
  logic        load_idx_s;

`ifdef PARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] lock_cnt_r, lock_cnt_s;
`else
  logic unused_lock_s;
  assign unused_lock_s = ^lock_s;
`endif

  assign req_s  = {bus.m1_req, bus.m0_req};
  assign lock_s = {bus.m1_lock, bus.m0_lock};
  // On a tie the pointer decides; otherwise the single requester wins.
  assign winner_s = (req_s == 2'b11) ? ptr_r : req_s[1];

  // Next-state, request latch and next registered-output values.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    we_s       = we_r;
    valid_s    = valid_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    rdata_s    = rdata_r;
    gnt_s      = 2'b00;
    rvalid_s   = 2'b00;
    rerr_s     = 2'b00;
    rd_s       = 1'b0;
    wr_s       = 1'b0;
    load_s     = 1'b0;
    load_idx_s = owner_r;
`ifdef PARB_LOCK_EN
    lock_cnt_s = lock_cnt_r;
`endif

    case (state_r)
      IDLE: begin
        if (|req_s) begin
          load_s     = 1'b1;
          load_idx_s = winner_s;
          state_s    = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s           = DONE;
        rvalid_s[owner_r] = 1'b1;
        rerr_s[owner_r]   = ~valid_r;
        // Writes and rejected addresses return zero data.
        rdata_s           = (valid_r && !we_r) ? bus.per_rdata : 32'h0000_0000;
      end
      DONE: begin
`ifdef PARB_LOCK_EN
        if (req_s[owner_r] && lock_s[owner_r] &&
            (lock_cnt_r < CNT_W'(LOCK_MAX - 1))) begin
          load_s     = 1'b1;
          load_idx_s = owner_r;
          state_s    = ACCESS;
          lock_cnt_s = lock_cnt_r + CNT_W'(1);
        end else begin
          state_s    = IDLE;
          ptr_s      = ~owner_r;
          lock_cnt_s = CNT_W'(0);
        end
`else
        state_s = IDLE;
        ptr_s   = ~owner_r;
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Capture the chosen master's request and launch the peripheral strobe.
    if (load_s) begin
      owner_s            = load_idx_s;
      we_s               = load_idx_s ? bus.m1_we    : bus.m0_we;
      addr_s             = load_idx_s ? bus.m1_addr  : bus.m0_addr;
      wdata_s            = load_idx_s ? bus.m1_wdata : bus.m0_wdata;
      valid_s            = addr_ok(addr_s);
      gnt_s[load_idx_s]  = 1'b1;
      rd_s               = valid_s & ~we_s;
      wr_s               = valid_s & we_s;
    end else begin
      gnt_s = 2'b00;
    end
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      ptr_r    <= 1'b0;
      owner_r  <= 1'b0;
      we_r     <= 1'b0;
      valid_r  <= 1'b0;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      gnt_r    <= 2'b00;
      rvalid_r <= 2'b00;
      rerr_r   <= 2'b00;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      owner_r  <= owner_s;
      we_r     <= we_s;
      valid_r  <= valid_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      rdata_r  <= rdata_s;
      gnt_r    <= gnt_s;
      rvalid_r <= rvalid_s;
      rerr_r   <= rerr_s;
      rd_r     <= rd_s;
      wr_r     <= wr_s;
    end
  end

`ifdef PARB_LOCK_EN
  // Consecutive locked-access counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt_r <= CNT_W'(0);
    end else begin
      lock_cnt_r <= lock_cnt_s;
    end
  end
`endif

  assign bus.m0_gnt    = gnt_r[0];
  assign bus.m1_gnt    = gnt_r[1];
  assign bus.m0_rvalid = rvalid_r[0];
  assign bus.m1_rvalid = rvalid_r[1];
  assign bus.m0_rerr   = rerr_r[0];
  assign bus.m1_rerr   = rerr_r[1];
  assign bus.m0_rdata  = rdata_r;
  assign bus.m1_rdata  = rdata_r;
  assign bus.per_addr  = addr_r;
  assign bus.per_wdata = wdata_r;
  assign bus.per_rd    = rd_r;
  assign bus.per_wr    = wr_r;
  assign bus.owner     = owner_r;

endmodule
